// File: rtl/dcls_recovery_ctrl_pkg.sv
// Shared hardisc definitions for the lockstep recovery controller: FSM encoding,
// default timing constants and a saturating-counter helper.
package p_hardisc;

    typedef enum logic [2:0] {
        RCV_RUN   = 3'd0,
        RCV_DRAIN = 3'd1,
        RCV_HOLD  = 3'd2,
        RCV_FATAL = 3'd3
    } rcv_state_t;

    localparam int unsigned RCV_RST_CYCLES_DEF    = 16;
    localparam int unsigned RCV_MAX_RETRY_DEF     = 3;
    localparam int unsigned RCV_WINDOW_DEF        = 65535;
    localparam int unsigned RCV_DRAIN_TIMEOUT_DEF = 64;

    function automatic logic [15:0] rcv_sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ahb_pend_tracker.sv
// Flags an AHB data phase that was accepted but has not yet completed.
module ahb_pend_tracker (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] htrans_i,
    input  logic       hready_i,
    input  logic       clr_i,
    output logic       pend_o
);

    logic pend_q;
    logic pend_d;
    logic unused_htrans0;

    assign unused_htrans0 = htrans_i[0];

    // HREADY high ends any current data phase; a new NONSEQ/SEQ starts the next one.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end else if (hready_i) begin
            pend_d = htrans_i[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/seu_ff_rst.sv
// Resettable register with a LABEL so fault-injection campaigns can target it by name.
module seu_ff_rst #(
    parameter string       LABEL   = "seu_ff",
    parameter int unsigned N       = 1,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    // Anchor for injection tooling that enumerates unlabelled instances.
    if (LABEL == "") begin : g_unlabelled
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/dcls_recovery_ctrl.sv
// Lockstep recovery controller: blocks the bus, drains data phases, pulses the core
// reset, and latches a fatal state when recoveries recur too often in one window.
module dcls_recovery_ctrl
    import p_hardisc::*;
#(
    parameter int unsigned RST_CYCLES    = RCV_RST_CYCLES_DEF,
    parameter int unsigned MAX_RETRY     = RCV_MAX_RETRY_DEF,
    parameter int unsigned WINDOW        = RCV_WINDOW_DEF,
    parameter int unsigned DRAIN_TIMEOUT = RCV_DRAIN_TIMEOUT_DEF
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_unrec_err_i,
    input  logic [1:0]  s_i_htrans_i,
    input  logic        s_i_hready_i,
    input  logic [1:0]  s_d_htrans_i,
    input  logic        s_d_hready_i,
    output logic        s_core_resetn_o,
    output logic        s_bus_block_o,
    output logic        s_recovering_o,
    output logic        s_fatal_o,
    output logic [3:0]  s_retry_cnt_o,
    output logic [15:0] s_err_total_o
);

    localparam int unsigned DrainW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int unsigned HoldW  = $clog2(RST_CYCLES);

    rcv_state_t        state_q, state_d;
    logic [2:0]        state_raw;
    logic [3:0]        retry_q, retry_d, retry_eff;
    logic [15:0]       total_q, total_d;
    logic [15:0]       window_q, window_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [3:0]        flags_q, flags_d;
    logic              resetn_d, block_d, recov_d, fatal_d;
    logic              ipend, dpend, pend_clr;

    assign state_q  = rcv_state_t'(state_raw);
    assign pend_clr = (state_q == RCV_HOLD) || (state_q == RCV_FATAL);

    ahb_pend_tracker u_ipend (
        .clk_i    (s_clk_i),
        .rst_i    (s_reset_i),
        .htrans_i (s_i_htrans_i),
        .hready_i (s_i_hready_i),
        .clr_i    (pend_clr),
        .pend_o   (ipend)
    );

    ahb_pend_tracker u_dpend (
        .clk_i    (s_clk_i),
        .rst_i    (s_reset_i),
        .htrans_i (s_d_htrans_i),
        .hready_i (s_d_hready_i),
        .clr_i    (pend_clr),
        .pend_o   (dpend)
    );

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        retry_eff = retry_q;
        total_d   = total_q;
        window_d  = window_q;
        drain_d   = drain_q;
        hold_d    = hold_q;
        resetn_d  = flags_q[0];
        block_d   = flags_q[1];
        recov_d   = flags_q[2];
        fatal_d   = flags_q[3];

        unique case (state_q)
            RCV_RUN: begin
                resetn_d = 1'b1;
                // Window expiry is resolved before a same-cycle error is counted.
                if (window_q != '0) begin
                    window_d = window_q - 16'd1;
                    if (window_q == 16'd1) begin
                        retry_eff = '0;
                    end
                end
                retry_d = retry_eff;
                if (s_unrec_err_i) begin
                    total_d = rcv_sat_inc16(total_q);
                    if (retry_eff == 4'(MAX_RETRY)) begin
                        state_d  = RCV_FATAL;
                        fatal_d  = 1'b1;
                        resetn_d = 1'b0;
                        block_d  = 1'b1;
                        recov_d  = 1'b0;
                    end else begin
                        state_d = RCV_DRAIN;
                        retry_d = retry_eff + 4'd1;
                        drain_d = DrainW'(DRAIN_TIMEOUT);
                        block_d = 1'b1;
                        recov_d = 1'b1;
                    end
                end
            end
            RCV_DRAIN: begin
                drain_d = drain_q - DrainW'(1);
                if ((!ipend && !dpend) || (drain_d == '0)) begin
                    state_d  = RCV_HOLD;
                    resetn_d = 1'b0;
                    hold_d   = HoldW'(RST_CYCLES - 1);
                end
            end
            RCV_HOLD: begin
                if (hold_q == '0) begin
                    state_d  = RCV_RUN;
                    resetn_d = 1'b1;
                    block_d  = 1'b0;
                    recov_d  = 1'b0;
                    window_d = 16'(WINDOW);
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            RCV_FATAL: begin
                fatal_d  = 1'b1;
                resetn_d = 1'b0;
                block_d  = 1'b1;
                recov_d  = 1'b0;
            end
            // A corrupted state encoding is treated as unrecoverable.
            default: begin
                state_d  = RCV_FATAL;
                fatal_d  = 1'b1;
                resetn_d = 1'b0;
                block_d  = 1'b1;
                recov_d  = 1'b0;
            end
        endcase

        flags_d = {fatal_d, recov_d, block_d, resetn_d};
    end

    seu_ff_rst #(.LABEL("rcv_state"), .N(3)) u_state_ff (
        .clk_i (s_clk_i), .rst_i (s_reset_i), .d_i (state_d), .q_o (state_raw)
    );
    seu_ff_rst #(.LABEL("rcv_retry"), .N(4)) u_retry_ff (
        .clk_i (s_clk_i), .rst_i (s_reset_i), .d_i (retry_d), .q_o (retry_q)
    );
    seu_ff_rst #(.LABEL("rcv_total"), .N(16)) u_total_ff (
        .clk_i (s_clk_i), .rst_i (s_reset_i), .d_i (total_d), .q_o (total_q)
    );
    seu_ff_rst #(.LABEL("rcv_window"), .N(16)) u_window_ff (
        .clk_i (s_clk_i), .rst_i (s_reset_i), .d_i (window_d), .q_o (window_q)
    );
    seu_ff_rst #(.LABEL("rcv_drain"), .N(DrainW)) u_drain_ff (
        .clk_i (s_clk_i), .rst_i (s_reset_i), .d_i (drain_d), .q_o (drain_q)
    );
    seu_ff_rst #(.LABEL("rcv_hold"), .N(HoldW)) u_hold_ff (
        .clk_i (s_clk_i), .rst_i (s_reset_i), .d_i (hold_d), .q_o (hold_q)
    );
    seu_ff_rst #(.LABEL("rcv_flags"), .N(4)) u_flags_ff (
        .clk_i (s_clk_i), .rst_i (s_reset_i), .d_i (flags_d), .q_o (flags_q)
    );

    assign s_core_resetn_o = flags_q[0];
    assign s_bus_block_o   = flags_q[1];
    assign s_recovering_o  = flags_q[2];
    assign s_fatal_o       = flags_q[3];
    assign s_retry_cnt_o   = retry_q;
    assign s_err_total_o   = total_q;

endmodule

// File: tb/tb_dcls_recovery_ctrl.sv
// Directed bench for dcls_recovery_ctrl: recovery timing, drain, timeout, escalation,
// window expiry and asynchronous reset.
module tb_dcls_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        err = 1'b0;
    logic [1:0]  i_htrans = 2'b00;
    logic        i_hready = 1'b1;
    logic [1:0]  d_htrans = 2'b00;
    logic        d_hready = 1'b1;
    logic        core_resetn, bus_block, recovering, fatal;
    logic [3:0]  retry_cnt;
    logic [15:0] err_total;

    int n_checks = 0;
    int n_errors = 0;

    dcls_recovery_ctrl dut (
        .s_clk_i         (clk),
        .s_reset_i       (rst),
        .s_unrec_err_i   (err),
        .s_i_htrans_i    (i_htrans),
        .s_i_hready_i    (i_hready),
        .s_d_htrans_i    (d_htrans),
        .s_d_hready_i    (d_hready),
        .s_core_resetn_o (core_resetn),
        .s_bus_block_o   (bus_block),
        .s_recovering_o  (recovering),
        .s_fatal_o       (fatal),
        .s_retry_cnt_o   (retry_cnt),
        .s_err_total_o   (err_total)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        err = 1'b0;
        i_htrans = 2'b00; i_hready = 1'b1;
        d_htrans = 2'b00; d_hready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic err_pulse();
        err = 1'b1;
        tick();
        err = 1'b0;
    endtask

    // Waits until recovery has finished; returns with the bus released.
    task automatic wait_recovered(input string tag);
        int n = 0;
        while ((recovering || !core_resetn) && n < 300) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, recovering}, 32'd0);
    endtask

    initial begin
        int n;
        logic ok;

        // Reset values
        #2 rst = 1'b1;
        #2;
        check_eq("rst_resetn", core_resetn, 0);
        check_eq("rst_block", bus_block, 0);
        check_eq("rst_flags", {recovering, fatal}, 0);
        check_eq("rst_counts", {retry_cnt, err_total}, 0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_release_resetn", core_resetn, 1);

        // Idle buses, single error: block at N+1, reset low N+2..N+17
        repeat (8) tick();
        err_pulse();
        check_eq("t1_block", bus_block, 1);
        check_eq("t1_recovering", recovering, 1);
        check_eq("t1_resetn_n1", core_resetn, 1);
        tick();
        check_eq("t1_resetn_n2", core_resetn, 0);
        n = 1;
        while (n < 40) begin
            tick();
            if (core_resetn) break;
            n++;
        end
        check_eq("t1_hold_len", n, 16);
        check_eq("t1_after_block", {bus_block, recovering}, 0);
        check_eq("t1_retry", retry_cnt, 1);
        check_eq("t1_total", err_total, 1);

        // Accepted data write with error, then 5 wait states
        do_reset();
        d_htrans = 2'b10; d_hready = 1'b1; err = 1'b1;
        tick();
        d_htrans = 2'b00; d_hready = 1'b0; err = 1'b0;
        check_eq("t2_block", bus_block, 1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!core_resetn || !bus_block) ok = 1'b0;
        end
        check_eq("t2_drain_wait", ok, 1);
        d_hready = 1'b1;
        tick();
        check_eq("t2_drain_done", {core_resetn, bus_block}, 2'b11);
        tick();
        check_eq("t2_hold", {core_resetn, bus_block}, 2'b01);
        wait_recovered("t2_recover");
        check_eq("t2_released", {core_resetn, bus_block}, 2'b10);

        // Data phase never completes: 64 DRAIN cycles then HOLD
        do_reset();
        d_htrans = 2'b10; d_hready = 1'b1; err = 1'b1;
        tick();
        d_htrans = 2'b00; d_hready = 1'b0; err = 1'b0;
        n = 1;
        while (n < 200) begin
            tick();
            if (!core_resetn) break;
            n++;
        end
        check_eq("t3_drain_len", n, 64);
        check_eq("t3_hold_block", bus_block, 1);
        wait_recovered("t3_recover");
        d_hready = 1'b1;

        // Four spaced errors: three recoveries, then fatal
        do_reset();
        for (int k = 0; k < 3; k++) begin
            repeat (100) tick();
            err_pulse();
            wait_recovered("t4_recover");
            check_eq("t4_retry", retry_cnt, k + 1);
        end
        repeat (100) tick();
        err_pulse();
        check_eq("t4_fatal", {fatal, core_resetn, bus_block, recovering}, 4'b1010);
        check_eq("t4_counts", {retry_cnt, err_total}, {4'd3, 16'd4});
        repeat (50) tick();
        err_pulse();
        repeat (50) tick();
        check_eq("t4_sticky", {fatal, core_resetn, bus_block, recovering}, 4'b1010);
        check_eq("t4_frozen", {retry_cnt, err_total}, {4'd3, 16'd4});
        do_reset();
        check_eq("t4_cleared", {fatal, core_resetn, retry_cnt}, {1'b0, 1'b1, 4'd0});

        // Window expiry coinciding with the next error
        err_pulse();
        wait_recovered("t5_recover");
        check_eq("t5_retry1", retry_cnt, 1);
        repeat (65534) tick();
        check_eq("t5_before_expiry", retry_cnt, 1);
        err_pulse();
        check_eq("t5_retry_after", retry_cnt, 1);
        check_eq("t5_total", err_total, 2);
        wait_recovered("t5_recover2");

        // Asynchronous reset in the 5th HOLD cycle
        do_reset();
        err_pulse();
        tick();
        repeat (4) tick();
        check_eq("t6_in_hold", {core_resetn, recovering}, 2'b01);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async", {core_resetn, bus_block, recovering, fatal}, 0);
        check_eq("t6_async_cnt", {retry_cnt, err_total}, 0);
        #3 rst = 1'b0;
        tick();
        check_eq("t6_release", {core_resetn, bus_block}, 2'b10);
        err_pulse();
        check_eq("t6_run_again", {bus_block, retry_cnt}, {1'b1, 4'd1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
